// File: rtl/box_plot_control.sv
// Box plot sequencer: latches an origin and colour on start, then walks a
// BOX_W x BOX_H raster emitting clipped pixel writes with back-pressure.
module box_plot_control #(
    parameter int BOX_W     = 4,
    parameter int BOX_H     = 4,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOUR_W  = 3,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int BG_COLOUR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                erase,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                pix_ready,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int CX_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int CY_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PLOT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [COLOUR_W-1:0] BG_C    = COLOUR_W'(BG_COLOUR);
    localparam logic [X_W:0]        SCR_W   = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]        SCR_H   = (Y_W+1)'(SCREEN_H);
    localparam logic [CX_W-1:0]     LAST_CX = CX_W'(BOX_W - 1);
    localparam logic [CY_W-1:0]     LAST_CY = CY_W'(BOX_H - 1);

    logic [1:0]          state_q, state_d;
    logic [X_W-1:0]      baseX_q, baseX_d;
    logic [Y_W-1:0]      baseY_q, baseY_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [CX_W-1:0]     cntX_q, cntX_d;
    logic [CY_W-1:0]     cntY_q, cntY_d;

    logic [X_W:0] sx;
    logic [Y_W:0] sy;
    logic         inPlot;
    logic         inBounds;
    logic         advance;
    logic         lastX;
    logic         lastY;

    // Sums are one bit wider so a box hanging off the right/bottom edge clips
    // instead of wrapping back onto the visible screen.
    assign sx       = {1'b0, baseX_q} + (X_W+1)'(cntX_q);
    assign sy       = {1'b0, baseY_q} + (Y_W+1)'(cntY_q);
    assign inPlot   = (state_q == S_PLOT);
    assign inBounds = (sx < SCR_W) && (sy < SCR_H);
    assign advance  = inPlot && (!inBounds || pix_ready);
    assign lastX    = (cntX_q == LAST_CX);
    assign lastY    = (cntY_q == LAST_CY);

    always_comb begin
        state_d  = state_q;
        baseX_d  = baseX_q;
        baseY_d  = baseY_q;
        colour_d = colour_q;
        cntX_d   = cntX_q;
        cntY_d   = cntY_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    baseX_d  = x_in;
                    baseY_d  = y_in;
                    colour_d = erase ? BG_C : colour_in;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                cntX_d  = '0;
                cntY_d  = '0;
                state_d = S_PLOT;
            end
            S_PLOT: begin
                if (advance) begin
                    if (lastX) begin
                        cntX_d = '0;
                        if (lastY) begin
                            state_d = S_DONE;
                        end else begin
                            cntY_d = cntY_q + 1'b1;
                        end
                    end else begin
                        cntX_d = cntX_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baseX_q  <= '0;
            baseY_q  <= '0;
            colour_q <= '0;
            cntX_q   <= '0;
            cntY_q   <= '0;
        end else begin
            state_q  <= state_d;
            baseX_q  <= baseX_d;
            baseY_q  <= baseY_d;
            colour_q <= colour_d;
            cntX_q   <= cntX_d;
            cntY_q   <= cntY_d;
        end
    end

    // Outputs decode purely from registers, so an async reset zeroes them at once.
    assign x_out      = inPlot ? sx[X_W-1:0] : '0;
    assign y_out      = inPlot ? sy[Y_W-1:0] : '0;
    assign colour_out = inPlot ? colour_q : '0;
    assign plot       = inPlot && inBounds;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_box_plot_control.sv
// Scoreboard bench for box_plot_control: default 4x4 instance plus a 3x2 instance.
module tb_box_plot_control;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       start2;
    logic       erase;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic       pix_ready;

    logic [7:0] x_out,  x2;
    logic [6:0] y_out,  y2;
    logic [2:0] colour_out, colour2;
    logic       plot, plot2, busy, busy2, done, done2;

    pix_t expQ[$];
    int   testsRun  = 0;
    int   failCount = 0;
    int   nPlot, nBusy, nDone, doneCyc;

    box_plot_control dut (
        .clk(clk), .reset(reset), .start(start), .erase(erase),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .pix_ready(pix_ready),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .plot(plot), .busy(busy), .done(done)
    );

    box_plot_control #(.BOX_W(3), .BOX_H(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .erase(erase),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .pix_ready(pix_ready),
        .x_out(x2), .y_out(y2), .colour_out(colour2),
        .plot(plot2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        testsRun++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected in-bounds pixels of one box, in raster order, on a 160x120 screen.
    task automatic pushBox(input int bx, input int by, input logic [2:0] c,
                           input int bw, input int bh);
        for (int j = 0; j < bh; j++) begin
            for (int i = 0; i < bw; i++) begin
                int sx;
                int sy;
                pix_t p;
                sx = bx + i;
                sy = by + j;
                if (sx < 160 && sy < 120) begin
                    p.x = 8'(sx);
                    p.y = 7'(sy);
                    p.c = c;
                    expQ.push_back(p);
                end
            end
        end
    endtask

    task automatic clearCounts();
        nPlot   = 0;
        nBusy   = 0;
        nDone   = 0;
        doneCyc = -1;
    endtask

    // Called at a falling edge: compares a plotted pixel with the queue head.
    task automatic sampleCycle(input bit useDut2, input int cyc);
        logic [7:0] ox;
        logic [6:0] oy;
        logic [2:0] oc;
        logic       op, ob, od;
        pix_t       e;
        ox = useDut2 ? x2      : x_out;
        oy = useDut2 ? y2      : y_out;
        oc = useDut2 ? colour2 : colour_out;
        op = useDut2 ? plot2   : plot;
        ob = useDut2 ? busy2   : busy;
        od = useDut2 ? done2   : done;
        if (op) begin
            nPlot++;
            if (expQ.size() == 0) begin
                checkOutput("extraPixel", 1, 0);
            end else begin
                e = expQ[0];
                checkOutput("pixX", int'(ox), int'(e.x));
                checkOutput("pixY", int'(oy), int'(e.y));
                checkOutput("pixColour", int'(oc), int'(e.c));
                if (pix_ready) void'(expQ.pop_front());
            end
        end
        if (ob) nBusy++;
        if (od) begin
            nDone++;
            doneCyc = cyc;
        end
    endtask

    task automatic applyStimulus(input int bx, input int by, input logic [2:0] c,
                                 input bit er, input bit useDut2,
                                 input int bw, input int bh,
                                 input int stallStart, input int stallLen,
                                 input bit midStart, input int expDone,
                                 input int expPlot);
        pushBox(bx, by, er ? 3'd0 : c, bw, bh);
        clearCounts();
        @(posedge clk); #1;
        x_in      = 8'(bx);
        y_in      = 7'(by);
        colour_in = c;
        erase     = er;
        pix_ready = 1'b1;
        if (useDut2) start2 = 1'b1;
        else         start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        start2 = 1'b0;
        for (int cyc = 1; cyc <= expDone + 4; cyc++) begin
            pix_ready = !(cyc >= stallStart && cyc < stallStart + stallLen);
            if (midStart && cyc == 5) begin
                start     = 1'b1;
                x_in      = 8'(bx + 40);
                y_in      = 7'(by + 30);
                colour_in = ~c;
            end else if (midStart && cyc == 6) begin
                start = 1'b0;
            end
            @(negedge clk);
            sampleCycle(useDut2, cyc);
            @(posedge clk); #1;
        end
        pix_ready = 1'b1;
        checkOutput("doneCount", nDone, 1);
        checkOutput("doneCycle", doneCyc, expDone);
        checkOutput("busyCycles", nBusy, expDone);
        checkOutput("plotCycles", nPlot, expPlot);
        checkOutput("pixelsLeft", expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        start2    = 1'b0;
        erase     = 1'b0;
        x_in      = '0;
        y_in      = '0;
        colour_in = '0;
        pix_ready = 1'b1;
        #12;
        checkOutput("resetPlot", int'(plot), 0);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetDone", int'(done), 0);
        checkOutput("resetX", int'(x_out), 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] basic 4x4 draw");
        applyStimulus(10, 20, 3'd5, 1'b0, 1'b0, 4, 4, 0, 0, 1'b0, 18, 16);

        $display("[TB] erase mode");
        applyStimulus(10, 20, 3'd5, 1'b1, 1'b0, 4, 4, 0, 0, 1'b0, 18, 16);

        $display("[TB] clipping at screen corner");
        applyStimulus(158, 118, 3'd6, 1'b0, 1'b0, 4, 4, 0, 0, 1'b0, 18, 4);

        $display("[TB] stall at pixel (2,1)");
        applyStimulus(50, 60, 3'd3, 1'b0, 1'b0, 4, 4, 8, 3, 1'b0, 21, 19);

        $display("[TB] async reset during pixel 7");
        pushBox(30, 40, 3'd2, 4, 4);
        clearCounts();
        @(posedge clk); #1;
        x_in = 8'd30; y_in = 7'd40; colour_in = 3'd2; erase = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            sampleCycle(1'b0, cyc);
            if (cyc != 9) begin
                @(posedge clk); #1;
            end
        end
        checkOutput("prePixel7Plot", int'(plot), 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abortPlot", int'(plot), 0);
        checkOutput("abortBusy", int'(busy), 0);
        checkOutput("abortX", int'(x_out), 0);
        checkOutput("abortY", int'(y_out), 0);
        checkOutput("abortColour", int'(colour_out), 0);
        expQ.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        clearCounts();
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            sampleCycle(1'b0, cyc);
        end
        checkOutput("abortNoDone", nDone, 0);
        checkOutput("abortNoBusy", nBusy, 0);
        applyStimulus(30, 40, 3'd2, 1'b0, 1'b0, 4, 4, 0, 0, 1'b0, 18, 16);

        $display("[TB] start during PLOT ignored");
        applyStimulus(70, 80, 3'd4, 1'b0, 1'b0, 4, 4, 0, 0, 1'b1, 18, 16);

        $display("[TB] 3x2 instance");
        applyStimulus(100, 90, 3'd7, 1'b0, 1'b1, 3, 2, 0, 0, 1'b0, 8, 6);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
